prueb_mic: RTL and testbench

//   I2S-style receiver for a single digital MEMS microphone.
//   - Generates the microphone bit clock (mclk) and word select (ws) from the system clock.
//   - Shifts in serial PCM data (dataint), MSB first, for the selected channel.
//   - Presents each completed sample on dataout with a one-cycle done strobe.
//   - Sits between the mic pins and the audio sample buffer / PCM processing logic.
//

---
 rtl/prueb_mic.sv | 94 +++++++++
 tb/tb_prueb_mic.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/prueb_mic.sv
// I2S-style receiver for one MEMS microphone: generates mclk/ws and captures
// DATA_BITS of MSB-first PCM from the selected ws slot.
module prueb_mic #(
   parameter int unsigned CLK_DIV   = 2,
   parameter int unsigned DATA_BITS = 16,
   parameter int unsigned SLOT_BITS = 32,
   parameter logic        CHANNEL   = 1'b0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 dataint,
   output logic                 mclk,
   output logic                 ws,
   output logic [DATA_BITS-1:0] dataout,
   output logic                 done
);

   localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned POS_W = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1;

   logic [DIV_W-1:0]     div_cnt;
   logic [POS_W-1:0]     bit_pos;
   logic [DATA_BITS-1:0] shift_reg;
   logic                 pend;

   logic tick_c;
   logic rise_c;
   logic fall_c;
   logic capture_c;
   logic last_bit_c;
   logic wrap_c;

   // Edge events and capture window (bit 0 of the slot is the I2S delay bit)
   always_comb begin
      tick_c     = (div_cnt == DIV_W'(CLK_DIV - 1));
      rise_c     = tick_c & ~mclk;
      fall_c     = tick_c & mclk;
      last_bit_c = (bit_pos == POS_W'(DATA_BITS));
      wrap_c     = (bit_pos == POS_W'(SLOT_BITS - 1));
      capture_c  = rise_c && (ws == CHANNEL) &&
                   (bit_pos >= POS_W'(1)) && (bit_pos <= POS_W'(DATA_BITS));
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         div_cnt   <= '0;
         mclk      <= 1'b0;
         ws        <= 1'b0;
         bit_pos   <= '0;
         shift_reg <= '0;
         dataout   <= '0;
         done      <= 1'b0;
         pend      <= 1'b0;
      end else if (!enable) begin
         div_cnt   <= '0;
         mclk      <= 1'b0;
         ws        <= 1'b0;
         bit_pos   <= '0;
         shift_reg <= '0;
         done      <= 1'b0;
         pend      <= 1'b0;
      end else begin
         // Publish the sample one cycle after its last bit lands in shift_reg
         done <= pend;
         if (pend) begin
            dataout <= shift_reg;
         end
         pend <= capture_c && last_bit_c;

         if (tick_c) begin
            div_cnt <= '0;
            mclk    <= ~mclk;
         end else begin
            div_cnt <= div_cnt + DIV_W'(1);
         end

         // Slot position and ws advance on the falling mclk edge
         if (fall_c) begin
            if (wrap_c) begin
               bit_pos <= '0;
               ws      <= ~ws;
            end else begin
               bit_pos <= bit_pos + POS_W'(1);
            end
         end

         if (capture_c) begin
            shift_reg <= {shift_reg[DATA_BITS-2:0], dataint};
         end
      end
   end

endmodule

// File: tb/tb_prueb_mic.sv
// Randomized bench for prueb_mic against a closed-form timing/sample model.
module tb_prueb_mic;

   localparam int CLK_DIV = 2;
   localparam int DB      = 16;
   localparam int SLOT    = 32;
   localparam int FRAME   = 2 * SLOT * 2 * CLK_DIV;
   localparam logic CH    = 1'b0;

   logic          clk = 1'b0;
   logic          reset;
   logic          enable;
   logic          dataint;
   logic          mclk;
   logic          ws;
   logic [DB-1:0] dataout;
   logic          done;

   prueb_mic #(
      .CLK_DIV  (CLK_DIV),
      .DATA_BITS(DB),
      .SLOT_BITS(SLOT),
      .CHANNEL  (CH)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .dataint(dataint),
      .mclk   (mclk),
      .ws     (ws),
      .dataout(dataout),
      .done   (done)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // reference model state: k = enabled clock edges since reset/enable
   int            k = 0;
   logic          e_mclk = 1'b0, e_ws = 1'b0, e_done = 1'b0, pend = 1'b0;
   logic [DB-1:0] e_dout = '0;
   int            acc = 0;

   logic          rst_v = 1'b0, en_v = 1'b1, fill_v = 1'b0, rnd_fill = 1'b1;
   logic [DB-1:0] word = '0;
   logic [DB-1:0] saved;
   int            ndone = 0, ndone_hi = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_chk++;
      if (obs === exp_v) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
   endtask

   function automatic int cur_bp();
      return (k / (2 * CLK_DIV)) % SLOT;
   endfunction

   function automatic logic cur_ws();
      return ((k / (2 * CLK_DIV * SLOT)) % 2) != 0;
   endfunction

   // Advance the model by one clock edge with the inputs that edge sees
   task automatic model(input logic r, input logic e, input logic d);
      int j, p, bp;
      logic wv;
      if (!r || !e) begin
         k = 0; e_mclk = 0; e_ws = 0; e_done = 0; pend = 0; acc = 0;
         if (!r) e_dout = '0;
      end else begin
         e_done = pend;
         if (pend) e_dout = DB'(acc);
         pend = 1'b0;
         if (k % CLK_DIV == CLK_DIV - 1) begin
            j = k / CLK_DIV;
            if (j % 2 == 0) begin
               p  = j / 2;
               bp = p % SLOT;
               wv = ((p / SLOT) % 2) != 0;
               if (wv == CH && bp >= 1 && bp <= DB) begin
                  acc = (acc * 2 + int'(d)) % (1 << DB);
                  if (bp == DB) pend = 1'b1;
               end
            end
         end
         k++;
         e_mclk = ((k / CLK_DIV) % 2) != 0;
         e_ws   = ((k / (2 * CLK_DIV * SLOT)) % 2) != 0;
      end
   endtask

   // One clock: drive at negedge, model at posedge, compare at next negedge
   task automatic step();
      int bp;
      logic wv, din;
      bp = cur_bp();
      wv = cur_ws();
      if (wv == CH && bp >= 1 && bp <= DB) din = word[DB-bp];
      else if (rnd_fill) din = 1'($urandom % 2);
      else din = (wv == CH) ? 1'b0 : fill_v;
      reset   = rst_v;
      enable  = en_v;
      dataint = din;
      @(posedge clk);
      model(rst_v, en_v, din);
      @(negedge clk);
      chk("mclk", 32'(mclk), 32'(e_mclk));
      chk("ws", 32'(ws), 32'(e_ws));
      chk("done", 32'(done), 32'(e_done));
      chk("dataout", 32'(dataout), 32'(e_dout));
      if (done === 1'b1) begin
         ndone++;
         if (ws === 1'b1) ndone_hi++;
      end
   endtask

   task automatic run_frame(input logic [DB-1:0] w, input string tag);
      word  = w;
      ndone = 0;
      repeat (FRAME) step();
      chk({tag, "_dout"}, 32'(dataout), 32'(w));
      chk({tag, "_ndone"}, 32'(ndone), 32'd1);
   endtask

   initial begin
      reset = 1'b0; enable = 1'b1; dataint = 1'b0;
      @(negedge clk);

      // reset held with enable high
      rst_v = 1'b0; en_v = 1'b1;
      repeat (5) step();
      chk("rst_mclk", 32'(mclk), 32'd0);
      chk("rst_dout", 32'(dataout), 32'd0);

      rst_v = 1'b1;
      run_frame(16'hA5C3, "a5c3");

      // zeros in our slot, ones in the other slot
      rnd_fill = 1'b0; fill_v = 1'b1; ndone_hi = 0;
      run_frame(16'h0000, "zero");
      chk("no_done_ws1", 32'(ndone_hi), 32'd0);
      rnd_fill = 1'b1;

      // enable drop mid-sample
      word = 16'hFFFF;
      for (int i = 0; i < 4 * FRAME && !(cur_bp() == 8 && cur_ws() == CH); i++) step();
      chk("reach_bp8", 32'(cur_bp() == 8 && cur_ws() == CH), 32'd1);
      saved = dataout; en_v = 1'b0; ndone = 0;
      repeat (6) step();
      chk("dis_dout", 32'(dataout), 32'(saved));
      chk("dis_ndone", 32'(ndone), 32'd0);
      chk("dis_mclk_ws", {30'd0, mclk, ws}, 32'd0);
      en_v = 1'b1;
      run_frame(16'h1234, "h1234");

      // one-cycle reset mid-sample
      word = 16'hFFFF;
      for (int i = 0; i < 4 * FRAME && !(cur_bp() == 10 && cur_ws() == CH); i++) step();
      chk("reach_bp10", 32'(cur_bp() == 10 && cur_ws() == CH), 32'd1);
      rst_v = 1'b0; ndone = 0;
      step();
      chk("mid_rst_out", {13'd0, mclk, ws, done, dataout}, 32'd0);
      rst_v = 1'b1;
      run_frame(DB'($urandom), "post_rst");

      // random words with random idle/reset gaps in between
      for (int f = 0; f < 6; f++) begin
         int gap;
         gap = int'($urandom_range(0, 7));
         if (gap > 0) begin
            if ($urandom % 2 == 0) en_v = 1'b0; else rst_v = 1'b0;
            repeat (gap) step();
            en_v = 1'b1; rst_v = 1'b1;
         end
         run_frame(DB'($urandom), "rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
